// File: rtl/hash_stream_pkg.sv
// Shared definitions for the packed hash-table stream interface:
// op codes, response flag offsets and the request packing helper.
package hash_stream_pkg;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;

  localparam int FLG_NO_DEL      = 0;
  localparam int FLG_NO_SPACE    = 1;
  localparam int FLG_NOT_FOUND   = 2;
  localparam int FLG_KEY_PRESENT = 3;

  localparam int PACK_MAX_W  = 128;
  localparam int FIELD_MAX_W = 64;

  // Width-generic packer: callers zero-extend their fields and keep the low
  // 2+key_w+data_w bits of the result.
  function automatic logic [PACK_MAX_W-1:0] pack_req(
    input logic [1:0]             op,
    input logic [FIELD_MAX_W-1:0] key,
    input logic [FIELD_MAX_W-1:0] data,
    input int                     key_w,
    input int                     data_w
  );
    logic [PACK_MAX_W-1:0] key_mask;
    logic [PACK_MAX_W-1:0] data_mask;
    key_mask  = (PACK_MAX_W'(1) << key_w) - PACK_MAX_W'(1);
    data_mask = (PACK_MAX_W'(1) << data_w) - PACK_MAX_W'(1);
    return (PACK_MAX_W'(op) << (key_w + data_w))
         | ((PACK_MAX_W'(key) & key_mask) << data_w)
         | (PACK_MAX_W'(data) & data_mask);
  endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous show-ahead FIFO; head entry is visible on pop_data while !empty.
// DEPTH must be a power of two.
module rsp_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign count    = CW'(wr_ptr - rd_ptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/hash_request_master.sv
// Client-side initiator for the hash-table stream: registers packed requests,
// buffers unpacked responses and limits the number of requests in flight.
module hash_request_master
  import hash_stream_pkg::*;
#(
  parameter int KEY_WIDTH       = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 cmd_valid_i,
  output logic                                 cmd_ready_o,
  input  logic [1:0]                           cmd_op_i,
  input  logic [KEY_WIDTH-1:0]                 cmd_key_i,
  input  logic [DATA_WIDTH-1:0]                cmd_data_i,
  output logic [2+KEY_WIDTH+DATA_WIDTH-1:0]    req_data_o,
  output logic                                 req_valid_o,
  input  logic                                 req_ready_i,
  input  logic [2+KEY_WIDTH+DATA_WIDTH-1:0]    rsp_data_i,
  input  logic                                 rsp_valid_i,
  output logic                                 rsp_ready_o,
  output logic                                 rsp_valid_o,
  input  logic                                 rsp_ready_i,
  output logic [DATA_WIDTH-1:0]                rsp_read_data_o,
  output logic                                 rsp_no_del_target_o,
  output logic                                 rsp_no_write_space_o,
  output logic                                 rsp_not_found_o,
  output logic                                 rsp_key_present_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] in_flight_o,
  output logic                                 protocol_err_o
);

  localparam int REQ_W = 2 + KEY_WIDTH + DATA_WIDTH;
  localparam int RSP_W = DATA_WIDTH + 4;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic                  cmd_accept;
  logic                  rsp_push;
  logic                  rsp_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [RSP_W-1:0]      fifo_rdata;
  logic [CNT_W-1:0]      fifo_count;
  logic [PACK_MAX_W-1:0] packed_full;
  logic                  unused_pack_bits;

  assign packed_full      = pack_req(cmd_op_i, FIELD_MAX_W'(cmd_key_i), FIELD_MAX_W'(cmd_data_i),
                                     KEY_WIDTH, DATA_WIDTH);
  assign unused_pack_bits = ^packed_full[PACK_MAX_W-1:REQ_W];

  assign cmd_ready_o = (!req_valid_o || req_ready_i) && (in_flight_o < CNT_W'(MAX_OUTSTANDING));
  assign cmd_accept  = cmd_valid_i && cmd_ready_o;
  assign rsp_ready_o = !fifo_full;
  assign rsp_push    = rsp_valid_i && rsp_ready_o;
  assign rsp_valid_o = !fifo_empty;
  assign rsp_pop     = rsp_valid_o && rsp_ready_i;

  // Request register: holds while stalled, reloads on accept, drains on handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_valid_o <= 1'b0;
      req_data_o  <= '0;
    end else if (cmd_accept) begin
      req_valid_o <= 1'b1;
      req_data_o  <= packed_full[REQ_W-1:0];
    end else if (req_ready_i) begin
      req_valid_o <= 1'b0;
    end
  end

  // Credit is returned only when the client consumes the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_flight_o <= '0;
    end else begin
      case ({cmd_accept, rsp_pop})
        2'b10:   in_flight_o <= in_flight_o + CNT_W'(1);
        2'b01:   if (in_flight_o != '0) in_flight_o <= in_flight_o - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      protocol_err_o <= 1'b0;
    end else if (rsp_push && (in_flight_o == fifo_count)) begin
      protocol_err_o <= 1'b1;
    end
  end

  rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rsp_push),
    .push_data (rsp_data_i[RSP_W-1:0]),
    .pop       (rsp_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  generate
    if (REQ_W > RSP_W) begin : g_unused_rsp
      logic unused_rsp_bits;
      assign unused_rsp_bits = ^rsp_data_i[REQ_W-1:RSP_W];
    end
  endgenerate

  // Unpacked fields read as zero whenever no response is presented.
  assign rsp_read_data_o      = rsp_valid_o ? fifo_rdata[DATA_WIDTH-1:0] : '0;
  assign rsp_no_del_target_o  = rsp_valid_o && fifo_rdata[DATA_WIDTH + FLG_NO_DEL];
  assign rsp_no_write_space_o = rsp_valid_o && fifo_rdata[DATA_WIDTH + FLG_NO_SPACE];
  assign rsp_not_found_o      = rsp_valid_o && fifo_rdata[DATA_WIDTH + FLG_NOT_FOUND];
  assign rsp_key_present_o    = rsp_valid_o && fifo_rdata[DATA_WIDTH + FLG_KEY_PRESENT];

endmodule
